conv_result_packer: RTL

CONV_RESULT_PACKER -- requirements
Module: conv_result_packer

---
 rtl/conv_result_packer_pkg.sv | 25 ++
 rtl/conv_result_packer_if.sv | 31 +++
 rtl/conv_result_packer_sync_fifo.sv | 59 +++++
 rtl/conv_result_packer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/conv_result_packer_pkg.sv
// Shared types and constants for the convolution result packer.
package conv_result_packer_pkg;

    // Drain sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // int8 results packed per 32-bit output word
    localparam int LANES = 4;

    // int8 clamp limits
    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    // One converted result: clamped byte plus "clamping changed the value" flag
    typedef struct packed {
        logic [7:0] val;
        logic       sat;
    } conv_t;

endpackage

// File: rtl/conv_result_packer_if.sv
// Result RAM read port plus the packed-word valid/ready output stream.
interface conv_result_packer_if #(
    parameter int RSLT_ADDR_WIDTH = 8,
    parameter int RSLT_DWIDTH     = 20
) ();

    logic        [RSLT_ADDR_WIDTH-1:0] rd_addr;
    logic signed [RSLT_DWIDTH-1:0]     rd_data;
    logic        [31:0]                out_data;
    logic                              out_valid;
    logic                              out_ready;

    // Packer side
    modport master (
        output rd_addr,
        input  rd_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    // RAM + consumer side
    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/conv_result_packer_sync_fifo.sv
// Single-clock FIFO; head word is presented straight from storage.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(DEPTH));
    // A push at full is accepted when the head leaves in the same cycle
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Storage, pointers and occupancy; reset empties and clears the array
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/conv_result_packer.sv
// Drains N signed results from the result RAM, converts each to int8
// (optional ReLU, then clamp), packs four per word and streams them out.
module conv_result_packer
    import conv_result_packer_pkg::*;
#(
    parameter int RSLT_ADDR_WIDTH = 8,
    parameter int RSLT_DWIDTH     = 20,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [RSLT_ADDR_WIDTH:0] count,
    input  logic                     relu_en,
    conv_result_packer_if.master     bus,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               sat_count
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW  = $clog2(LANES);
    localparam logic signed [RSLT_DWIDTH-1:0] SAT_HI  = RSLT_DWIDTH'(INT8_MAX);
    localparam logic signed [RSLT_DWIDTH-1:0] SAT_LO  = RSLT_DWIDTH'(INT8_MIN);
    localparam logic        [RSLT_ADDR_WIDTH:0] ONE_N = 1;
    localparam logic        [FCW:0]             OCC_LIMIT = (FCW+1)'(FIFO_DEPTH - 1);

    state_t state_q, state_d;

    logic [RSLT_ADDR_WIDTH:0]   n_q;
    logic                       relu_q;
    logic [RSLT_ADDR_WIDTH-1:0] rd_addr_q;

    logic                       vld_p0;
    logic                       last_p0;
    logic [LW-1:0]              lane_idx_p0;
    logic [31:0]                acc_p0;
    logic                       vld_p1;
    logic [31:0]                word_p1;

    logic [FCW-1:0]             fifo_cnt;
    logic                       fifo_empty;
    logic [31:0]                fifo_dout;
    logic                       pop;

    logic                       start_ok;
    logic                       issue_ok;
    logic                       issue;
    logic                       issue_last;
    logic                       partial;
    logic                       pipe_empty;
    logic                       closing;
    logic [FCW:0]               occ;
    conv_t                      conv;
    logic [31:0]                word_next;

    // ReLU first, then clamp to int8; only the clamp counts as saturation
    function automatic conv_t to_int8(input logic signed [RSLT_DWIDTH-1:0] v,
                                      input logic relu);
        logic signed [RSLT_DWIDTH-1:0] r;
        conv_t res;
        r = (relu && v[RSLT_DWIDTH-1]) ? '0 : v;
        res.sat = 1'b0;
        res.val = r[7:0];
        if (r > SAT_HI) begin
            res.val = 8'h7F;
            res.sat = 1'b1;
        end else if (r < SAT_LO) begin
            res.val = 8'h80;
            res.sat = 1'b1;
        end
        return res;
    endfunction

    assign start_ok   = start && (state_q == IDLE || state_q == DONE);
    assign issue_last = (({1'b0, rd_addr_q} + ONE_N) == n_q);
    // Words already committed to the FIFO or still being assembled downstream
    assign partial    = vld_p0 || (lane_idx_p0 != '0);
    assign occ        = {1'b0, fifo_cnt} + (FCW+1)'(vld_p1) + (FCW+1)'(partial);
    assign issue_ok   = (occ < OCC_LIMIT);
    assign issue      = (state_q == READ) && issue_ok;
    assign pipe_empty = !vld_p0 && !vld_p1 && (lane_idx_p0 == '0);

    assign conv      = to_int8(bus.rd_data, relu_q);
    assign word_next = acc_p0 | (32'(conv.val) << {lane_idx_p0, 3'b000});
    assign closing   = (lane_idx_p0 == LW'(LANES - 1)) || last_p0;

    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_dout;
    assign bus.rd_addr   = rd_addr_q;

    assign busy = (state_q == READ) || (state_q == FLUSH);
    assign done = (state_q == DONE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: FLUSH ends on the handshake that empties the whole path
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (count == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue && issue_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (pipe_empty && pop && fifo_cnt == FCW'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain parameters and read address; address holds at N-1 on the last issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q       <= '0;
            relu_q    <= 1'b0;
            rd_addr_q <= '0;
        end else if (start_ok) begin
            n_q       <= count;
            relu_q    <= relu_en;
            rd_addr_q <= '0;
        end else if (issue && !issue_last) begin
            rd_addr_q <= rd_addr_q + 1'b1;
        end
    end

    // p0: RAM data returns; convert, place in lane, close word on lane 3 or last
    // p1: closed word waits one cycle, then is pushed into the FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0      <= 1'b0;
            last_p0     <= 1'b0;
            lane_idx_p0 <= '0;
            acc_p0      <= '0;
            vld_p1      <= 1'b0;
            word_p1     <= '0;
            sat_count   <= '0;
        end else begin
            vld_p0  <= issue;
            last_p0 <= issue && issue_last;
            vld_p1  <= 1'b0;
            if (start_ok) begin
                lane_idx_p0 <= '0;
                acc_p0      <= '0;
                sat_count   <= '0;
            end else if (vld_p0) begin
                if (conv.sat && sat_count != 8'hFF) begin
                    sat_count <= sat_count + 1'b1;
                end
                if (closing) begin
                    word_p1     <= word_next;
                    vld_p1      <= 1'b1;
                    acc_p0      <= '0;
                    lane_idx_p0 <= '0;
                end else begin
                    acc_p0      <= word_next;
                    lane_idx_p0 <= lane_idx_p0 + 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (vld_p1),
        .din     (word_p1),
        .pop     (pop),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

endmodule
